// File: rtl/riscv_mini_pkg.sv
// rtl/riscv_mini_pkg.sv - shared constants and types for the RISC-V Mini front end
package riscv_mini_pkg;

  localparam int INSTR_W = 16;

  localparam logic [1:0] OP_R = 2'b00;
  localparam logic [1:0] OP_I = 2'b01;
  localparam logic [1:0] OP_L = 2'b10;
  localparam logic [1:0] OP_S = 2'b11;

  // opcode 11, funct3 000: display of x0, no register writeback
  localparam logic [15:0] INSTR_NOP = 16'h0003;

  typedef enum logic {
    S_LO = 1'b0,
    S_HI = 1'b1
  } asm_state_e;

endpackage

// File: rtl/instr_queue_if.sv
// rtl/instr_queue_if.sv - byte-in / instruction-out bundle of the instruction queue
interface instr_queue_if #(
  parameter int DEPTH   = 8,
  parameter int INSTR_W = 16
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]         byte_in;
  logic               byte_valid;
  logic               byte_ready;
  logic               flush;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic [CW-1:0]      count;
  logic               full;
  logic               empty;

  modport master (
    output byte_in, byte_valid, flush, instr_ready,
    input  byte_ready, instr, instr_valid, count, full, empty
  );

  modport slave (
    input  byte_in, byte_valid, flush, instr_ready,
    output byte_ready, instr, instr_valid, count, full, empty
  );

endinterface

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - synchronous FIFO with extended pointers, registered status and flush
module instr_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     valid
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [AW:0]      wr_nxt, rd_nxt;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // next pointer values; status flags are derived from these so they stay registered
  always_comb begin
    wr_nxt = wr_ptr + {{AW{1'b0}}, do_push};
    rd_nxt = rd_ptr + {{AW{1'b0}}, do_pop};
  end

  // pointers and status; flush clears everything and wins over push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      valid  <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      valid  <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      count  <= wr_nxt - rd_nxt;
      full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
      empty  <= (wr_nxt == rd_nxt);
      valid  <= (wr_nxt != rd_nxt);
    end
  end

  // storage is never cleared; stale entries are hidden behind empty
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - byte-to-instruction assembler and staging queue ahead of the Mini core
module instr_queue #(
  parameter int DEPTH   = 8,
  parameter int INSTR_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  instr_queue_if.slave bus
);

  import riscv_mini_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  asm_state_e         state;
  logic [7:0]         lo_reg;
  logic               accept;
  logic               push;
  logic               pop;
  logic [INSTR_W-1:0] head;
  logic [CW-1:0]      count;
  logic               full;
  logic               empty;
  logic               valid;

  // a low byte may always be taken; a high byte needs a free slot
  assign bus.byte_ready = (state == S_LO) || !full;
  assign accept         = bus.byte_valid && bus.byte_ready;
  assign push           = accept && (state == S_HI);
  assign pop            = valid && bus.instr_ready;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.flush),
    .push      (push),
    .push_data ({bus.byte_in, lo_reg}),
    .pop       (pop),
    .rd_data   (head),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .valid     (valid)
  );

  // assembler: capture the low byte, then push the word on the high byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_LO;
      lo_reg <= 8'h00;
    end else if (bus.flush) begin
      state  <= S_LO;
    end else if (accept) begin
      if (state == S_LO) begin
        lo_reg <= bus.byte_in;
        state  <= S_HI;
      end else begin
        state  <= S_LO;
      end
    end
  end

  assign bus.instr       = empty ? INSTR_NOP : head;
  assign bus.instr_valid = valid;
  assign bus.count       = count;
  assign bus.full        = full;
  assign bus.empty       = empty;

endmodule

// File: tb/tb_instr_queue.sv
// tb/tb_instr_queue.sv - directed self-checking bench for instr_queue
module tb_instr_queue;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  instr_queue_if #(.DEPTH(8), .INSTR_W(16)) bus ();

  instr_queue #(.DEPTH(8), .INSTR_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  b;
    logic        bv;
    logic        fl;
    logic        rdy;
    logic [15:0] e_instr;
    logic        e_valid;
    logic [3:0]  e_count;
    logic        e_br;
  } vec_t;

  vec_t vecs [12];
  logic [15:0] q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    while (!bus.byte_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: got byte_ready=0 expected 1 within 20 cycles");
    end
    tick();
    bus.byte_valid = 1'b0;
  endtask

  task automatic push_instr(input logic [15:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_instr"}, 32'(bus.instr), 32'h0003);
    check({tag, "_valid"}, 32'(bus.instr_valid), 32'h0);
    check({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'h1);
    check({tag, "_count"}, 32'(bus.count), 32'h0);
    check({tag, "_full"}, 32'(bus.full), 32'h0);
    check({tag, "_empty"}, 32'(bus.empty), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] w;

    bus.byte_in     = 8'h00;
    bus.byte_valid  = 1'b0;
    bus.flush       = 1'b0;
    bus.instr_ready = 1'b0;

    vecs[0]  = '{8'h25, 1'b1, 1'b0, 1'b0, 16'h0003, 1'b0, 4'd0, 1'b1};
    vecs[1]  = '{8'h40, 1'b1, 1'b0, 1'b0, 16'h4025, 1'b1, 4'd1, 1'b1};
    vecs[2]  = '{8'h00, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b0, 4'd0, 1'b1};
    vecs[3]  = '{8'h11, 1'b1, 1'b0, 1'b0, 16'h0003, 1'b0, 4'd0, 1'b1};
    vecs[4]  = '{8'h22, 1'b1, 1'b0, 1'b0, 16'h2211, 1'b1, 4'd1, 1'b1};
    vecs[5]  = '{8'h33, 1'b1, 1'b0, 1'b0, 16'h2211, 1'b1, 4'd1, 1'b1};
    vecs[6]  = '{8'h44, 1'b1, 1'b0, 1'b1, 16'h4433, 1'b1, 4'd1, 1'b1};
    vecs[7]  = '{8'h00, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b0, 4'd0, 1'b1};
    vecs[8]  = '{8'h55, 1'b1, 1'b1, 1'b0, 16'h0003, 1'b0, 4'd0, 1'b1};
    vecs[9]  = '{8'h66, 1'b1, 1'b0, 1'b0, 16'h0003, 1'b0, 4'd0, 1'b1};
    vecs[10] = '{8'h77, 1'b1, 1'b0, 1'b0, 16'h7766, 1'b1, 4'd1, 1'b1};
    vecs[11] = '{8'h00, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b0, 4'd0, 1'b1};

    // power-on reset
    #12;
    check_reset_state("por");
    #5 rst_n = 1'b1;
    tick();

    // table: single instruction, push/pop overlap, flush dropping a low byte
    for (int i = 0; i < 12; i++) begin
      bus.byte_in     = vecs[i].b;
      bus.byte_valid  = vecs[i].bv;
      bus.flush       = vecs[i].fl;
      bus.instr_ready = vecs[i].rdy;
      tick();
      check($sformatf("vec%0d_instr", i), 32'(bus.instr), 32'(vecs[i].e_instr));
      check($sformatf("vec%0d_valid", i), 32'(bus.instr_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].e_count));
      check($sformatf("vec%0d_byte_ready", i), 32'(bus.byte_ready), 32'(vecs[i].e_br));
    end
    bus.byte_valid  = 1'b0;
    bus.flush       = 1'b0;
    bus.instr_ready = 1'b0;

    // asynchronous reset mid-cycle with data queued and a low byte pending
    push_instr(16'h1234);
    send_byte(8'hAB);
    check("pre_rst_count", 32'(bus.count), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    #2 rst_n = 1'b1;
    tick();
    push_instr(16'h7788);
    check("post_rst_instr", 32'(bus.instr), 32'h7788);
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    check("post_rst_empty", 32'(bus.empty), 32'h1);

    // fill to full, then a ninth instruction whose high byte must wait
    for (int i = 0; i < 8; i++) begin
      w = 16'h0100 + 16'(i);
      push_instr(w);
    end
    check("fill_full", 32'(bus.full), 32'h1);
    check("fill_count", 32'(bus.count), 32'd8);
    check("fill_br_lo", 32'(bus.byte_ready), 32'h1);
    send_byte(8'h09);
    check("full_br_hi", 32'(bus.byte_ready), 32'h0);
    bus.byte_in    = 8'h02;
    bus.byte_valid = 1'b1;
    tick();
    check("held_br", 32'(bus.byte_ready), 32'h0);
    check("held_count", 32'(bus.count), 32'd8);
    check("full_head", 32'(bus.instr), 32'h0100);
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    check("free_count", 32'(bus.count), 32'd7);
    check("free_full", 32'(bus.full), 32'h0);
    check("free_br", 32'(bus.byte_ready), 32'h1);
    check("free_head", 32'(bus.instr), 32'h0101);
    tick();
    bus.byte_valid = 1'b0;
    check("refill_count", 32'(bus.count), 32'd8);
    check("refill_full", 32'(bus.full), 32'h1);
    bus.instr_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      w = (i < 8) ? 16'h0100 + 16'(i) : 16'h0209;
      check($sformatf("drain%0d", i), 32'(bus.instr), 32'(w));
      tick();
    end
    bus.instr_ready = 1'b0;
    check("drain_empty", 32'(bus.empty), 32'h1);
    check("drain_nop", 32'(bus.instr), 32'h0003);

    // steady push+pop at count 3 across pointer wraps
    for (int i = 0; i < 3; i++) begin
      w = 16'hA000 + 16'(i);
      push_instr(w);
      q.push_back(w);
    end
    check("pp_start_count", 32'(bus.count), 32'd3);
    for (int i = 0; i < 10; i++) begin
      w = 16'hB000 + 16'(i * 17);
      bus.byte_in     = w[7:0];
      bus.byte_valid  = 1'b1;
      bus.instr_ready = 1'b0;
      tick();
      bus.byte_in     = w[15:8];
      bus.instr_ready = 1'b1;
      check($sformatf("pp%0d_head", i), 32'(bus.instr), 32'(q[0]));
      tick();
      void'(q.pop_front());
      q.push_back(w);
      check($sformatf("pp%0d_count", i), 32'(bus.count), 32'd3);
    end
    bus.byte_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("pp_drain%0d", i), 32'(bus.instr), 32'(q[0]));
      void'(q.pop_front());
      tick();
    end
    bus.instr_ready = 1'b0;
    check("pp_empty", 32'(bus.empty), 32'h1);

    // flush with two queued and a pending low byte
    push_instr(16'hC001);
    push_instr(16'hC002);
    check("fl_pre_count", 32'(bus.count), 32'd2);
    send_byte(8'hEE);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("fl_empty", 32'(bus.empty), 32'h1);
    check("fl_count", 32'(bus.count), 32'd0);
    check("fl_valid", 32'(bus.instr_valid), 32'h0);
    push_instr(16'h6003);
    check("fl_word", 32'(bus.instr), 32'h6003);
    check("fl_word_count", 32'(bus.count), 32'd1);

    // flush on the same edge as a high-byte push and a pop
    send_byte(8'h11);
    bus.byte_in     = 8'h22;
    bus.byte_valid  = 1'b1;
    bus.flush       = 1'b1;
    bus.instr_ready = 1'b1;
    tick();
    bus.byte_valid  = 1'b0;
    bus.flush       = 1'b0;
    bus.instr_ready = 1'b0;
    check("flpp_count", 32'(bus.count), 32'd0);
    check("flpp_valid", 32'(bus.instr_valid), 32'h0);
    check("flpp_instr", 32'(bus.instr), 32'h0003);
    tick();
    check("flpp_still_empty", 32'(bus.empty), 32'h1);
    push_instr(16'h6655);
    check("flpp_next_word", 32'(bus.instr), 32'h6655);
    check("flpp_next_count", 32'(bus.count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
